// File: rtl/sap_cpu_pkg.sv
// Shared opcodes, FSM state type and field widths for the parametrised SAP core.
package sap_cpu_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_STA = 4'h4;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
  localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    StLoad,
    StLdone,
    StT0,
    StT1,
    StT2,
    StT3,
    StHalt
  } sap_state_e;

endpackage

// File: rtl/sap_ram.sv
// Flop-based RAM: combinational read, one synchronous write port, no reset so
// contents survive a core reset.
module sap_ram #(
  parameter int unsigned DataW = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sap_cpu_core.sv
// Multicycle SAP-style accumulator core with valid/ready program loader.
// Define SAP_COND_JUMP_EN to enable JC/JZ; otherwise opcodes 7 and 8 act as NOP.
module sap_cpu_core
  import sap_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_en,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] dbg_pc
);

`ifdef SAP_COND_JUMP_EN
  localparam bit CondJumpEn = 1'b1;
`else
  localparam bit CondJumpEn = 1'b0;
`endif

  sap_state_e        state_q;
  logic [ADDR_W-1:0] pc_q, mar_q, load_addr_q;
  logic [OPC_W-1:0]  ir_opc_q;
  logic [ADDR_W-1:0] ir_opd_q;
  logic [DATA_W-1:0] a_q, out_q;
  logic              cf_q, zf_q;
  logic              prog_ready_q, prog_done_q, out_valid_q, halted_q;

  logic [DATA_W-1:0] ram_rdata, ram_wdata, operand_ext;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_we, load_fire, last_load, enter_run;
  logic [DATA_W:0]   sum, diff;

  // Only the opcode and operand fields of IR are ever consumed.
  assign operand_ext = {{(DATA_W - ADDR_W){1'b0}}, ir_opd_q};
  assign load_fire   = (state_q == StLoad) && prog_en && prog_valid && prog_ready_q;
  assign last_load   = (load_addr_q == {ADDR_W{1'b1}});
  assign enter_run   = !prog_en && ((state_q == StLoad) || (state_q == StLdone));

  assign sum  = {1'b0, a_q} + {1'b0, ram_rdata};
  assign diff = {1'b0, a_q} - {1'b0, ram_rdata};

  // Loader and STA never share a state, so the mux only needs the state.
  assign ram_we    = !rst && (load_fire || ((state_q == StT3) && (ir_opc_q == OP_STA)));
  assign ram_waddr = (state_q == StLoad) ? load_addr_q : mar_q;
  assign ram_wdata = (state_q == StLoad) ? prog_data : a_q;

  sap_ram #(
    .DataW(DATA_W),
    .AddrW(ADDR_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(mar_q),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= prog_en ? StLoad : StT0;
      prog_ready_q <= prog_en;
      prog_done_q  <= 1'b0;
      pc_q         <= '0;
      mar_q        <= '0;
      load_addr_q  <= '0;
      ir_opc_q     <= '0;
      ir_opd_q     <= '0;
      a_q          <= '0;
      cf_q         <= 1'b0;
      zf_q         <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (load_fire) begin
            load_addr_q <= load_addr_q + ADDR_W'(1);
            if (last_load) begin
              state_q      <= StLdone;
              prog_ready_q <= 1'b0;
              prog_done_q  <= 1'b1;
            end
          end
        end
        StLdone: begin
        end
        StT0: begin
          mar_q   <= pc_q;
          state_q <= StT1;
        end
        StT1: begin
          ir_opc_q <= ram_rdata[DATA_W-1 -: OPC_W];
          ir_opd_q <= ram_rdata[ADDR_W-1:0];
          pc_q     <= pc_q + ADDR_W'(1);
          state_q  <= StT2;
        end
        StT2: begin
          state_q <= StT3;
          case (ir_opc_q)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_q <= ir_opd_q;
            OP_LDI: a_q <= operand_ext;
            OP_JMP: pc_q <= ir_opd_q;
            OP_JC:  if (CondJumpEn && cf_q) pc_q <= ir_opd_q;
            OP_JZ:  if (CondJumpEn && zf_q) pc_q <= ir_opd_q;
            OP_OUT: begin
              out_q       <= a_q;
              out_valid_q <= 1'b1;
            end
            OP_HLT: begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end
            default: begin
            end
          endcase
        end
        StT3: begin
          state_q <= StT0;
          case (ir_opc_q)
            OP_LDA: a_q <= ram_rdata;
            OP_ADD: begin
              a_q  <= sum[DATA_W-1:0];
              cf_q <= sum[DATA_W];
              zf_q <= (sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              a_q  <= diff[DATA_W-1:0];
              cf_q <= !diff[DATA_W];
              zf_q <= (diff[DATA_W-1:0] == '0);
            end
            default: begin
            end
          endcase
        end
        StHalt: begin
          if (prog_en) begin
            state_q      <= StLoad;
            prog_ready_q <= 1'b1;
          end
        end
        default: state_q <= StT0;
      endcase

      // Leaving the loader always starts a fresh run from address 0.
      if (enter_run) begin
        state_q      <= StT0;
        prog_ready_q <= 1'b0;
        prog_done_q  <= 1'b0;
        pc_q         <= '0;
        a_q          <= '0;
        cf_q         <= 1'b0;
        zf_q         <= 1'b0;
        load_addr_q  <= '0;
        halted_q     <= 1'b0;
      end
    end
  end

  assign prog_ready = prog_ready_q;
  assign prog_done  = prog_done_q;
  assign out_data   = out_q;
  assign out_valid  = out_valid_q;
  assign halted     = halted_q;
  assign dbg_pc     = pc_q;

endmodule
